// File: rtl/irc_pkg.sv
// Shared definitions for the IR-remote command controller.
// Default key codes, mode encodings and state enums.
package irc_pkg;

    localparam logic [7:0] DEF_KEY_M0   = 8'd12;
    localparam logic [7:0] DEF_KEY_M1   = 8'd24;
    localparam logic [7:0] DEF_KEY_M2   = 8'd94;
    localparam logic [7:0] DEF_KEY_ZIN  = 8'd21;
    localparam logic [7:0] DEF_KEY_ZOUT = 8'd7;

    localparam logic [23:0] DEF_MODE_CODES =
        {DEF_KEY_M2, DEF_KEY_M1, DEF_KEY_M0};

    localparam logic [2:0] MODE_OH_0 = 3'b001;
    localparam logic [2:0] MODE_OH_1 = 3'b010;
    localparam logic [2:0] MODE_OH_2 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF
    } beep_state_t;

    typedef enum logic [1:0] {
        ZK_NONE,
        ZK_INC,
        ZK_DEC
    } zoom_key_t;

endpackage

// File: rtl/irc_beep_seq.sv
// Buzzer sequencer: N short beeps or one long rejection beep.
// Owns the beep FSM, the in-slot cycle counter and the beeps-left count.
module irc_beep_seq
    import irc_pkg::*;
#(
    parameter int BEEP_PERIOD = 12_500_000,
    parameter int BEEP_ON     = 6_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       long_req,
    input  logic [2:0] count,
    output logic       beep_n,
    output logic       busy
);

    localparam int CW = $clog2(BEEP_PERIOD + 1);

    localparam logic [CW-1:0] ON_LAST       = CW'(BEEP_ON - 1);
    localparam logic [CW-1:0] OFF_LAST      = CW'(BEEP_PERIOD - BEEP_ON - 1);
    localparam logic [CW-1:0] LONG_ON_LAST  = CW'(BEEP_PERIOD - 2);
    localparam logic [CW-1:0] LONG_OFF_LAST = CW'(0);

    beep_state_t   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    left, left_d;
    logic          lng, lng_d;
    logic [CW-1:0] on_last, off_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            left  <= '0;
            lng   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            left  <= left_d;
            lng   <= lng_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        left_d   = left;
        lng_d    = lng;
        on_last  = lng ? LONG_ON_LAST : ON_LAST;
        off_last = lng ? LONG_OFF_LAST : OFF_LAST;
        case (state)
            ST_ON: begin
                if (cnt == on_last) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_OFF: begin
                if (cnt == off_last) begin
                    cnt_d = '0;
                    if (left != 3'd0) begin
                        state_d = ST_ON;
                        left_d  = left - 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A mode sequence always restarts; a rejection never interrupts one
        if (start) begin
            state_d = ST_ON;
            cnt_d   = '0;
            left_d  = count - 3'd1;
            lng_d   = 1'b0;
        end else if (long_req && !(busy && !lng)) begin
            state_d = ST_ON;
            cnt_d   = '0;
            left_d  = 3'd0;
            lng_d   = 1'b1;
        end
    end

    assign beep_n = (state != ST_ON);
    assign busy   = (state != ST_IDLE);

endmodule

// File: rtl/irc_cmd_ctrl.sv
// IR-remote command controller: mode select, zoom stepping, buzzer feedback.
// Define IRC_AUTOREPEAT_EN to let key_rpt repeat the last zoom key.
module irc_cmd_ctrl
    import irc_pkg::*;
#(
    parameter int                     NUM_MODES   = 3,
    parameter logic [NUM_MODES*8-1:0] MODE_CODES  = DEF_MODE_CODES,
    parameter logic [7:0]             KEY_INC     = DEF_KEY_ZIN,
    parameter logic [7:0]             KEY_DEC     = DEF_KEY_ZOUT,
    parameter int                     DW          = 11,
    parameter int                     W_STEP      = 40,
    parameter int                     H_STEP      = 15,
    parameter int                     W_MIN       = 800,
    parameter int                     W_MAX       = 1600,
    parameter int                     H_MIN       = 600,
    parameter int                     H_MAX       = 900,
    parameter int                     W_INIT      = 1280,
    parameter int                     H_INIT      = 780,
    parameter int                     BEEP_PERIOD = 12_500_000,
    parameter int                     BEEP_ON     = 6_250_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_vld,
    input  logic [7:0]           key_code,
    input  logic                 key_rpt,
    output logic [NUM_MODES-1:0] mode,
    output logic [DW-1:0]        dst_w,
    output logic [DW-1:0]        dst_h,
    output logic                 limit_hit,
    output logic                 beep_n,
    output logic                 beep_busy
);

    localparam logic [DW:0] W_STEP_X = (DW+1)'(W_STEP);
    localparam logic [DW:0] H_STEP_X = (DW+1)'(H_STEP);
    localparam logic [DW:0] W_MAX_X  = (DW+1)'(W_MAX);
    localparam logic [DW:0] H_MAX_X  = (DW+1)'(H_MAX);
    localparam logic [DW:0] W_LO_X   = (DW+1)'(W_MIN + W_STEP);
    localparam logic [DW:0] H_LO_X   = (DW+1)'(H_MIN + H_STEP);

    logic       mode_hit;
    logic [2:0] mode_idx;
    logic       mode_take;

    always_comb begin
        mode_hit = 1'b0;
        mode_idx = 3'd0;
        // Descending scan so the lowest matching slice wins
        for (int k = NUM_MODES - 1; k >= 0; k--) begin
            if (MODE_CODES[k*8 +: 8] == key_code) begin
                mode_hit = 1'b1;
                mode_idx = 3'(k);
            end
        end
    end

    assign mode_take = key_vld && mode_hit;

    logic          key_inc, key_dec;
    logic          do_inc, do_dec;
    logic [DW:0]   w_ext, h_ext, w_up, h_up;
    logic          inc_ok, dec_ok;
    logic          step_up, step_dn, reject;

    assign key_inc = key_vld && (key_code == KEY_INC);
    assign key_dec = key_vld && (key_code == KEY_DEC);

`ifdef IRC_AUTOREPEAT_EN
    zoom_key_t last_key;
    logic      rpt;

    assign rpt    = key_rpt && !key_vld;
    assign do_inc = key_inc || (rpt && last_key == ZK_INC);
    assign do_dec = key_dec || (rpt && last_key == ZK_DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= ZK_NONE;
        end else if (key_vld) begin
            if (key_inc)      last_key <= ZK_INC;
            else if (key_dec) last_key <= ZK_DEC;
            else              last_key <= ZK_NONE;
        end
    end
`else
    logic unused_rpt;

    assign unused_rpt = key_rpt;
    assign do_inc     = key_inc;
    assign do_dec     = key_dec;
`endif

    assign w_ext  = {1'b0, dst_w};
    assign h_ext  = {1'b0, dst_h};
    assign w_up   = w_ext + W_STEP_X;
    assign h_up   = h_ext + H_STEP_X;
    assign inc_ok = (w_up <= W_MAX_X) && (h_up <= H_MAX_X);
    assign dec_ok = (w_ext >= W_LO_X) && (h_ext >= H_LO_X);

    assign step_up = do_inc && inc_ok;
    assign step_dn = do_dec && dec_ok;
    assign reject  = (do_inc && !inc_ok) || (do_dec && !dec_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= NUM_MODES'(1);
            dst_w     <= DW'(W_INIT);
            dst_h     <= DW'(H_INIT);
            limit_hit <= 1'b0;
        end else begin
            if (mode_take) mode <= NUM_MODES'(1) << mode_idx;
            if (step_up) begin
                dst_w <= w_up[DW-1:0];
                dst_h <= h_up[DW-1:0];
            end else if (step_dn) begin
                dst_w <= dst_w - DW'(W_STEP);
                dst_h <= dst_h - DW'(H_STEP);
            end
            limit_hit <= reject;
        end
    end

    irc_beep_seq #(
        .BEEP_PERIOD (BEEP_PERIOD),
        .BEEP_ON     (BEEP_ON)
    ) u_beep (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mode_take),
        .long_req (reject),
        .count    (mode_idx + 3'd1),
        .beep_n   (beep_n),
        .busy     (beep_busy)
    );

endmodule

// File: tb/tb_irc_cmd_ctrl.sv
// Scoreboard bench for irc_cmd_ctrl with a short beep period (20/10).
// Stimulus queues timed expectations; a negedge monitor retires them.
module tb_irc_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_vld = 1'b0;
    logic        key_rpt = 1'b0;
    logic [7:0]  key_code = 8'd0;
    logic [2:0]  mode;
    logic [10:0] dst_w, dst_h;
    logic        limit_hit, beep_n, beep_busy;

    always #5 clk = ~clk;

    irc_cmd_ctrl #(
        .BEEP_PERIOD (20),
        .BEEP_ON     (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_vld   (key_vld),
        .key_code  (key_code),
        .key_rpt   (key_rpt),
        .mode      (mode),
        .dst_w     (dst_w),
        .dst_h     (dst_h),
        .limit_hit (limit_hit),
        .beep_n    (beep_n),
        .beep_busy (beep_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_MODE, K_W, K_H, K_LIM, K_BEEP, K_BUSY} kind_t;
    typedef struct {
        int          at;
        kind_t       kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [15:0] observe(kind_t k);
        case (k)
            K_MODE:  return {13'd0, mode};
            K_W:     return {5'd0, dst_w};
            K_H:     return {5'd0, dst_h};
            K_LIM:   return {15'd0, limit_hit};
            K_BEEP:  return {15'd0, beep_n};
            default: return {15'd0, beep_busy};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                logic [15:0] a;
                a = observe(q[i].kind);
                total++;
                if (a !== q[i].val) begin
                    bad++;
                    $display("FAIL %s at cycle %0d: got %0d want %0d",
                             q[i].name, cyc, a, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic push(int at, kind_t k, int v, string n);
        exp_t e;
        e.at   = at;
        e.kind = k;
        e.val  = v[15:0];
        e.name = n;
        q.push_back(e);
    endtask

    task automatic dims(int at, int w, int h);
        push(at, K_W, w, "dst_w");
        push(at, K_H, h, "dst_h");
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [7:0] code, input logic rpt, output int c);
        key_code = code;
        key_vld  = 1'b1;
        key_rpt  = rpt;
        c = cyc;
        @(posedge clk);
        #1;
        key_vld = 1'b0;
        key_rpt = 1'b0;
    endtask

    task automatic rpt_pulse(output int c);
        key_rpt = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        key_rpt = 1'b0;
    endtask

    // Expected buzzer trace from a trigger at cycle c, up to cycle lim
    task automatic beeps(int c, int n, bit lng, int lim);
        int span;
        span = lng ? 20 : 20 * n;
        for (int t = 1; t <= span + 15; t++) begin
            int bn, bz;
            if (c + t > lim) break;
            if (lng) begin
                bn = (t <= 19) ? 0 : 1;
            end else begin
                bn = (((t - 1) / 20) < n && ((t - 1) % 20) < 10) ? 0 : 1;
            end
            bz = (t <= span) ? 1 : 0;
            push(c + t, K_BEEP, bn, "beep_n");
            push(c + t, K_BUSY, bz, "beep_busy");
        end
    endtask

    localparam int BIG = 32'h3fff_ffff;

    initial begin
        int c, c2, w, h, guard;

        idle(2);
        rst_n = 1'b1;
        c = cyc;
        push(c, K_MODE, 1, "reset_mode");
        dims(c, 1280, 780);
        push(c, K_LIM, 0, "reset_limit");
        push(c, K_BEEP, 1, "reset_beep_n");
        push(c, K_BUSY, 0, "reset_busy");
        idle(2);

        key(8'd24, 1'b0, c);
        push(c + 1, K_MODE, 2, "mode_key24");
        beeps(c, 2, 1'b0, BIG);
        idle(60);

        w = 1280;
        h = 780;
        for (int i = 0; i < 8; i++) begin
            key(8'd21, 1'b0, c);
            w += 40;
            h += 15;
            dims(c + 1, w, h);
            push(c + 1, K_LIM, 0, "zin_limit");
            push(c + 1, K_BEEP, 1, "zin_beep_n");
        end
        key(8'd21, 1'b0, c);
        dims(c + 1, 1600, 900);
        push(c + 1, K_LIM, 1, "zin_reject");
        push(c + 2, K_LIM, 0, "zin_reject_end");
        beeps(c, 1, 1'b1, BIG);
        idle(60);

        key(8'd94, 1'b0, c);
        push(c + 1, K_MODE, 4, "mode_key94");
        beeps(c, 3, 1'b0, c + 25);
        wait_until(c + 25);
        key(8'd12, 1'b0, c2);
        push(c2 + 1, K_MODE, 1, "mode_key12");
        beeps(c2, 1, 1'b0, BIG);
        idle(60);

        key(8'd24, 1'b0, c);
        push(c + 1, K_MODE, 2, "mode_pre_reset");
        beeps(c, 2, 1'b0, c + 4);
        wait_until(c + 5);
        rst_n = 1'b0;
        push(cyc, K_BEEP, 1, "rst_beep_n");
        push(cyc, K_BUSY, 0, "rst_busy");
        push(cyc, K_MODE, 1, "rst_mode");
        dims(cyc, 1280, 780);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        w = 1280;
        h = 780;
        for (int i = 0; i < 12; i++) begin
            key(8'd7, 1'b0, c);
            w -= 40;
            h -= 15;
            dims(c + 1, w, h);
            push(c + 1, K_LIM, 0, "zout_limit");
        end
        key(8'd7, 1'b0, c);
        dims(c + 1, 800, 600);
        push(c + 1, K_LIM, 1, "zout_reject");
        beeps(c, 1, 1'b1, BIG);
        idle(60);

        key(8'd99, 1'b0, c);
        for (int t = 1; t <= 5; t++) begin
            dims(c + t, 800, 600);
            push(c + t, K_MODE, 1, "unk_mode");
            push(c + t, K_BEEP, 1, "unk_beep_n");
            push(c + t, K_BUSY, 0, "unk_busy");
            push(c + t, K_LIM, 0, "unk_limit");
        end
        idle(10);

`ifdef IRC_AUTOREPEAT_EN
        key(8'd21, 1'b0, c);
        dims(c + 1, 840, 615);
        for (int i = 0; i < 3; i++) begin
            rpt_pulse(c);
            dims(c + 1, 880 + 40 * i, 630 + 15 * i);
            push(c + 1, K_BEEP, 1, "rpt_beep_n");
        end
        key(8'd21, 1'b1, c);
        dims(c + 1, 1000, 675);
        key(8'd12, 1'b0, c);
        push(c + 1, K_MODE, 1, "rpt_mode_key12");
        dims(c + 1, 1000, 675);
        beeps(c, 1, 1'b0, BIG);
        rpt_pulse(c);
        dims(c + 1, 1000, 675);
        push(c + 1, K_LIM, 0, "rpt_cleared_limit");
        idle(60);
`else
        key(8'd21, 1'b0, c);
        dims(c + 1, 840, 615);
        rpt_pulse(c);
        dims(c + 1, 840, 615);
        push(c + 1, K_LIM, 0, "rpt_ignored_limit");
        push(c + 1, K_BEEP, 1, "rpt_ignored_beep_n");
        idle(5);
`endif

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
